// File: rtl/cpu_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus fields,
// privilege encodings, exception codes and trap sequencer types.
package cpu_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_COMMIT,
    TRAP_REDIRECT
  } trap_state_e;

  typedef enum logic {
    KIND_ENTRY,
    KIND_MRET
  } trap_kind_e;

endpackage

// File: rtl/trap_mstatus_calc.sv
// Combinational mstatus update and next privilege for trap entry or MRET.
module trap_mstatus_calc
  import cpu_csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [1:0]      priv_i,
  input  logic            is_mret_i,
  output logic [XLEN-1:0] mstatus_o,
  output logic [1:0]      priv_o
);

  // Entry stacks MIE into MPIE and records the trapped-from privilege in MPP;
  // MRET unstacks and returns to the privilege held in MPP.
  always_comb begin
    mstatus_o = mstatus_i;
    priv_o    = PRIV_M;
    if (is_mret_i) begin
      mstatus_o[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
      mstatus_o[MSTATUS_MPIE]                  = 1'b1;
      mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
      priv_o                                   = mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    end else begin
      mstatus_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
      mstatus_o[MSTATUS_MIE]                   = 1'b0;
      mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_i;
      priv_o                                   = PRIV_M;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions and MRET, commits the
// CSR update values, then redirects the PC. Owns the current privilege.
module trap_ctrl
  import cpu_csr_pkg::*;
#(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            csr_exc_en,
  input  logic [3:0]      csr_exc_code,
  input  logic [XLEN-1:0] csr_exc_val,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mcause_in,
  input  logic [XLEN-1:0] mtval_in,
  input  logic [XLEN-1:0] mtvec_trap,
  output logic            trap_taken,
  output logic            trap_done,
  output logic [XLEN-1:0] mepc_next,
  output logic [XLEN-1:0] mcause_next,
  output logic [XLEN-1:0] mtval_next,
  output logic [XLEN-1:0] mstatus_next,
  output logic [1:0]      priv_lvl,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] ms_calc;
  logic [1:0]      priv_calc;
  logic            unused_bits;

  // Direct-mode vectoring and word-aligned PCs never look at the low two bits.
  assign unused_bits = ^{mtvec_trap[1:0], pc_q[1:0]};

  trap_mstatus_calc #(.XLEN(XLEN)) u_mstatus_calc (
    .mstatus_i (mstatus_q),
    .priv_i    (priv_q),
    .is_mret_i (kind_q == KIND_MRET),
    .mstatus_o (ms_calc),
    .priv_o    (priv_calc)
  );

  // State register; reset always lands in IDLE so no pulse follows a reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= TRAP_IDLE;
    else     state_q <= state_d;
  end

  // Latched request record; only meaningful while COMMIT/REDIRECT are active.
  always_ff @(posedge clk) begin
    kind_q    <= kind_d;
    cause_q   <= cause_d;
    tval_q    <= tval_d;
    pc_q      <= pc_d;
    mstatus_q <= mstatus_d;
  end

  // Privilege changes only at the end of COMMIT.
  always_ff @(posedge clk) begin
    if (rst)                           priv_q <= RESET_PRIV;
    else if (state_q == TRAP_COMMIT)   priv_q <= priv_calc;
  end

  // Arbitration, next state and Moore outputs.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    pc_d           = pc_q;
    mstatus_d      = mstatus_q;
    trap_taken     = 1'b0;
    trap_done      = 1'b0;
    mepc_next      = '0;
    mcause_next    = '0;
    mtval_next     = '0;
    mstatus_next   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      TRAP_IDLE: begin
        if (exc_req || csr_exc_en || mret_req) begin
          state_d   = TRAP_COMMIT;
          mstatus_d = mstatus_in;
          kind_d    = KIND_ENTRY;
          pc_d      = exc_pc;
          if (exc_req) begin
            cause_d = exc_cause;
            tval_d  = exc_tval;
          end else if (csr_exc_en) begin
            cause_d = csr_exc_code;
            tval_d  = csr_exc_val;
          end else if (priv_q != PRIV_M) begin
            // MRET outside M-mode is an illegal instruction
            cause_d = EXC_ILLEGAL_INSTR;
            tval_d  = '0;
          end else begin
            kind_d  = KIND_MRET;
            cause_d = '0;
            tval_d  = '0;
            pc_d    = mepc_in;
          end
        end
      end
      TRAP_COMMIT: begin
        state_d      = TRAP_REDIRECT;
        mstatus_next = ms_calc;
        if (kind_q == KIND_ENTRY) begin
          trap_taken  = 1'b1;
          mepc_next   = {pc_q[XLEN-1:2], 2'b00};
          mcause_next = {{(XLEN-4){1'b0}}, cause_q};
          mtval_next  = tval_q;
        end else begin
          trap_done   = 1'b1;
          mepc_next   = mepc_in;
          mcause_next = mcause_in;
          mtval_next  = mtval_in;
        end
      end
      TRAP_REDIRECT: begin
        state_d        = TRAP_IDLE;
        redirect_valid = 1'b1;
        if (kind_q == KIND_ENTRY) redirect_pc = {mtvec_trap[XLEN-1:2], 2'b00};
        else                      redirect_pc = {pc_q[XLEN-1:2], 2'b00};
      end
      default: state_d = TRAP_IDLE;
    endcase
  end

  assign priv_lvl = priv_q;
  assign busy     = (state_q != TRAP_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: cycle-scheduled reference model plus directed vectors.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_req = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [63:0] exc_tval = '0;
  logic [63:0] exc_pc = '0;
  logic        csr_exc_en = 1'b0;
  logic [3:0]  csr_exc_code = '0;
  logic [63:0] csr_exc_val = '0;
  logic        mret_req = 1'b0;
  logic [63:0] mstatus_in = '0;
  logic [63:0] mepc_in = '0;
  logic [63:0] mcause_in = 64'h77;
  logic [63:0] mtval_in = 64'h55;
  logic [63:0] mtvec_trap = 64'h4103;
  logic        trap_taken, trap_done, redirect_valid, busy;
  logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next, redirect_pc;
  logic [1:0]  priv_lvl;

  trap_ctrl #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
    .csr_exc_en(csr_exc_en), .csr_exc_code(csr_exc_code), .csr_exc_val(csr_exc_val),
    .mret_req(mret_req),
    .mstatus_in(mstatus_in), .mepc_in(mepc_in), .mcause_in(mcause_in), .mtval_in(mtval_in),
    .mtvec_trap(mtvec_trap),
    .trap_taken(trap_taken), .trap_done(trap_done),
    .mepc_next(mepc_next), .mcause_next(mcause_next), .mtval_next(mtval_next),
    .mstatus_next(mstatus_next), .priv_lvl(priv_lvl),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Expected output schedule: one record per future cycle, tagged by cycle number.
  typedef struct {
    int          tag;
    bit          tt, td, rv, hold, from_mtvec;
    logic [63:0] mepc, mcause, mtval, mstatus, rpc;
  } exp_t;

  exp_t        ring [8];
  int          free_at = 0;
  int          pend_at = -1;
  logic [1:0]  pend_val = 2'b11;
  logic [1:0]  m_priv = 2'b11;
  exp_t        e, c1, c2;
  bit          m_entry, ev;
  logic [3:0]  m_cs;
  logic [63:0] m_tv, m_ms;

  function automatic logic [2:0] slot(input int c);
    return c[2:0];
  endfunction

  function automatic exp_t blank(input int t);
    exp_t r;
    r.tag = t; r.tt = 0; r.td = 0; r.rv = 0; r.hold = 0; r.from_mtvec = 0;
    r.mepc = '0; r.mcause = '0; r.mtval = '0; r.mstatus = '0; r.rpc = '0;
    return r;
  endfunction

  initial for (int i = 0; i < 8; i++) ring[i] = blank(-1);

  // Compare this cycle's outputs to the schedule, then fold in this cycle's inputs.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      e  = ring[slot(cyc)];
      ev = (e.tag == cyc);
      chk("trap_taken", {63'b0, trap_taken}, {63'b0, ev && e.tt});
      chk("trap_done", {63'b0, trap_done}, {63'b0, ev && e.td});
      chk("redirect_valid", {63'b0, redirect_valid}, {63'b0, ev && e.rv});
      chk("busy", {63'b0, busy}, {63'b0, cyc < free_at});
      chk("priv_lvl", {62'b0, priv_lvl}, {62'b0, m_priv});
      chk("mepc_next", mepc_next, !ev ? 64'h0 : (e.hold ? mepc_in : e.mepc));
      chk("mcause_next", mcause_next, !ev ? 64'h0 : (e.hold ? mcause_in : e.mcause));
      chk("mtval_next", mtval_next, !ev ? 64'h0 : (e.hold ? mtval_in : e.mtval));
      chk("mstatus_next", mstatus_next, ev ? e.mstatus : 64'h0);
      chk("redirect_pc", redirect_pc,
          !(ev && e.rv) ? 64'h0 : (e.from_mtvec ? (mtvec_trap & ~64'h3) : e.rpc));
    end
    if (rst) begin
      ring[slot(cyc + 1)] = blank(-1);
      ring[slot(cyc + 2)] = blank(-1);
      free_at = cyc + 1;
      pend_at = -1;
      m_priv  = 2'b11;
    end else begin
      if (cyc >= free_at && (exc_req || csr_exc_en || mret_req)) begin
        m_ms = mstatus_in;
        m_entry = 1'b1;
        if (exc_req) begin
          m_cs = exc_cause; m_tv = exc_tval;
        end else if (csr_exc_en) begin
          m_cs = csr_exc_code; m_tv = csr_exc_val;
        end else if (m_priv != 2'b11) begin
          m_cs = 4'd2; m_tv = '0;
        end else begin
          m_entry = 1'b0; m_cs = '0; m_tv = '0;
        end
        c1 = blank(cyc + 1);
        c2 = blank(cyc + 2);
        c2.rv = 1;
        if (m_entry) begin
          c1.tt      = 1;
          c1.mepc    = exc_pc & ~64'h3;
          c1.mcause  = {60'b0, m_cs};
          c1.mtval   = m_tv;
          c1.mstatus = (m_ms & ~64'h1888) | (m_ms[3] ? 64'h80 : 64'h0) | ({62'b0, m_priv} << 11);
          c2.from_mtvec = 1;
          pend_val = 2'b11;
        end else begin
          c1.td      = 1;
          c1.hold    = 1;
          c1.mstatus = (m_ms & ~64'h1888) | (m_ms[7] ? 64'h8 : 64'h0) | 64'h80;
          c2.rpc     = mepc_in & ~64'h3;
          pend_val   = m_ms[12:11];
        end
        ring[slot(cyc + 1)] = c1;
        ring[slot(cyc + 2)] = c2;
        pend_at = cyc + 2;
        free_at = cyc + 3;
      end
      if (pend_at == cyc + 1) m_priv = pend_val;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exc_req = 1'b0; csr_exc_en = 1'b0; mret_req = 1'b0;
  endtask

  // Issue an MRET with the given mstatus/mepc and walk it to completion.
  task automatic do_mret(input logic [63:0] ms, input logic [63:0] ep);
    mstatus_in = ms; mepc_in = ep; mret_req = 1'b1;
    step(); clr();
    @(negedge clk);
    @(negedge clk);
    step(); step();
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {63'b0, busy}, 64'h0);
    chk("reset priv", {62'b0, priv_lvl}, 64'h3);
    chk("reset redirect_pc", redirect_pc, 64'h0);
    step();

    // MRET in M-mode returning to M
    mstatus_in = 64'h1880; mepc_in = 64'h1000; mret_req = 1'b1;
    step(); clr();
    @(negedge clk);
    chk("mret trap_done", {63'b0, trap_done}, 64'h1);
    chk("mret trap_taken", {63'b0, trap_taken}, 64'h0);
    chk("mret mstatus_next", mstatus_next, 64'h88);
    chk("mret mepc_next", mepc_next, 64'h1000);
    @(negedge clk);
    chk("mret redirect_pc", redirect_pc, 64'h1000);
    chk("mret priv", {62'b0, priv_lvl}, 64'h3);
    step(); step();

    // MRET down to U-mode
    mstatus_in = 64'h0080; mepc_in = 64'h2002; mret_req = 1'b1;
    step(); clr();
    @(negedge clk);
    chk("mret-u mstatus_next", mstatus_next, 64'h88);
    @(negedge clk);
    chk("mret-u redirect_pc", redirect_pc, 64'h2000);
    chk("mret-u priv", {62'b0, priv_lvl}, 64'h0);
    step(); step();

    // MRET from U-mode becomes an illegal-instruction trap
    mstatus_in = 64'h0; exc_pc = 64'h3000; mret_req = 1'b1;
    step(); clr();
    @(negedge clk);
    chk("illegal mret trap_taken", {63'b0, trap_taken}, 64'h1);
    chk("illegal mret trap_done", {63'b0, trap_done}, 64'h0);
    chk("illegal mret mcause", mcause_next, 64'h2);
    chk("illegal mret mtval", mtval_next, 64'h0);
    @(negedge clk);
    chk("illegal mret redirect_pc", redirect_pc, 64'h4100);
    chk("illegal mret priv", {62'b0, priv_lvl}, 64'h3);
    step(); step();

    // back to U, then a pipeline exception; mtvec changes after the commit
    do_mret(64'h0080, 64'h5000);
    exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 64'h8000_0106; exc_tval = 64'h1234;
    mstatus_in = 64'h8;
    step(); clr(); mtvec_trap = 64'h9002;
    @(negedge clk);
    chk("exc trap_taken", {63'b0, trap_taken}, 64'h1);
    chk("exc mepc_next", mepc_next, 64'h8000_0104);
    chk("exc mcause_next", mcause_next, 64'h2);
    chk("exc mtval_next", mtval_next, 64'h1234);
    chk("exc mstatus_next", mstatus_next, 64'h80);
    @(negedge clk);
    chk("exc redirect_pc", redirect_pc, 64'h9000);
    chk("exc priv", {62'b0, priv_lvl}, 64'h3);
    step(); step();

    // exception beats CSR exception; a second request while busy is ignored
    mstatus_in = 64'h1808;
    exc_req = 1'b1; exc_cause = 4'd4; csr_exc_en = 1'b1; csr_exc_code = 4'd2;
    step(); clr();
    exc_req = 1'b1; exc_cause = 4'd7;
    @(negedge clk);
    chk("prio mcause_next", mcause_next, 64'h4);
    chk("prio busy N+1", {63'b0, busy}, 64'h1);
    chk("prio mstatus_next", mstatus_next, 64'h1880);
    step(); clr();
    @(negedge clk);
    chk("prio busy N+2", {63'b0, busy}, 64'h1);
    step();
    @(negedge clk);
    chk("ignored trap_taken", {63'b0, trap_taken}, 64'h0);
    chk("ignored busy", {63'b0, busy}, 64'h0);
    step();

    // CSR-access exception alone
    csr_exc_en = 1'b1; csr_exc_code = 4'd5; csr_exc_val = 64'hdead; exc_pc = 64'h7003;
    step(); clr();
    @(negedge clk);
    chk("csr mcause_next", mcause_next, 64'h5);
    chk("csr mtval_next", mtval_next, 64'hdead);
    chk("csr mepc_next", mepc_next, 64'h7000);
    step(); step(); step();

    // exception and MRET together: MRET dropped
    exc_req = 1'b1; exc_cause = 4'd3; mret_req = 1'b1; mepc_in = 64'h6000;
    step(); clr();
    @(negedge clk);
    chk("exc+mret trap_taken", {63'b0, trap_taken}, 64'h1);
    chk("exc+mret trap_done", {63'b0, trap_done}, 64'h0);
    step(); step(); step();

    // reset during COMMIT of an MRET to U-mode
    mstatus_in = 64'h0080; mepc_in = 64'h2000; mret_req = 1'b1;
    step(); clr(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst-commit redirect_valid", {63'b0, redirect_valid}, 64'h0);
    chk("rst-commit priv", {62'b0, priv_lvl}, 64'h3);
    chk("rst-commit busy", {63'b0, busy}, 64'h0);
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that sits directly upstream of the machine CSR file. It arbitrates exception sources (pipeline exceptions, CSR-access exceptions, MRET) and computes the next mepc/mcause/mtval/mstatus values. It pulses trap_taken/trap_done into the CSR file, then redirects the PC to the trap vector or the return address. It also owns the current privilege level (`priv_lvl`).

## Interface
Parameters:
- XLEN, 64, data/address width
- RESET_PRIV, 2'b11, privilege level after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- exc_req  in  1  pipeline exception, valid for one cycle
- exc_cause  in  4  pipeline exception code
- exc_tval  in  XLEN  pipeline faulting value
- exc_pc  in  XLEN  PC of the excepting or MRET instruction
- csr_exc_en  in  1  CSR-file access exception
- csr_exc_code  in  4  CSR exception code
- csr_exc_val  in  XLEN  CSR exception value
- mret_req  in  1  MRET retiring
- mstatus_in, mepc_in, mcause_in, mtval_in  in  XLEN  current CSR values
- mtvec_trap  in  XLEN  mtvec latched by the CSR file on trap_taken
- trap_taken  out  1  trap-entry commit pulse
- trap_done  out  1  MRET commit pulse
- mepc_next, mcause_next, mtval_next, mstatus_next  out  XLEN  CSR update values, valid while trap_taken or trap_done is high
- priv_lvl  out  2  current privilege (0 = U, 1 = S, 3 = M)
- redirect_valid  out  1  PC redirect/flush pulse
- redirect_pc  out  XLEN  target PC
- busy  out  1  high in any state other than IDLE; pipeline stalls on it

## Operation
- FSM states: IDLE, COMMIT, REDIRECT.
- IDLE:
  - Samples requests each cycle.
  - If any request wins arbitration, latch its kind, cause, tval, pc and mstatus_in, then go to COMMIT.
  - Otherwise stay in IDLE.
- COMMIT (1 cycle): pulse trap_taken (entry) or trap_done (MRET), drive the *_next values, go to REDIRECT.
- REDIRECT (1 cycle): pulse redirect_valid, go to IDLE.
- Arbitration priority: exc_req > csr_exc_en > mret_req.
- MRET when priv_lvl != 3 is converted to an entry with cause 2 and tval 0.
- Trap-entry values:
  - mepc_next = {pc[63:2], 2'b00}
  - mcause_next = {60'b0, cause}; bit 63 is always 0 (no interrupts in this block)
  - mtval_next = tval
  - mstatus_next: MPIE[7] ← MIE[3]; MIE[3] ← 0; MPP[12:11] ← priv_lvl; all other bits unchanged
  - priv_lvl ← 3 in COMMIT
- Entry redirect: redirect_pc = {mtvec_trap[63:2], 2'b00}. Direct mode only; mtvec[1:0] is ignored.
- MRET values:
  - mepc_next = mepc_in, mcause_next = mcause_in, mtval_next = mtval_in (hold)
  - mstatus_next: MIE ← MPIE; MPIE ← 1; MPP ← 2'b00
  - priv_lvl ← latched MPP in COMMIT
  - redirect_pc = latched mepc_in, bits [1:0] cleared
- Requests arriving in COMMIT or REDIRECT are ignored. Upstream must hold them off using busy.

## Timing
- Request in cycle N → trap_taken/trap_done in N+1 → redirect_valid in N+2 → IDLE in N+3, when a new request can be accepted.
- mtvec_trap is read in REDIRECT, one cycle after the CSR file latches it on trap_taken.
- trap_taken, trap_done and redirect_valid are single-cycle pulses. trap_taken and trap_done are mutually exclusive.
- Reset values: state IDLE; priv_lvl = RESET_PRIV; all pulses, busy, *_next and redirect_pc = 0.
- Reset asserted in COMMIT or REDIRECT: no pulse is emitted the following cycle, priv_lvl returns to RESET_PRIV, state returns to IDLE.
- exc_req and mret_req in the same cycle: the exception wins and the MRET is dropped.

## Structure
- Shared package cpu_csr_pkg holds:
  - CSR address constants
  - mstatus bit positions (MIE = 3, MPIE = 7, MPP = 12:11)
  - privilege encodings (PRIV_U/S/M)
  - exception codes (ILLEGAL_INSTR = 2)
  - FSM state enum
- One sub-module, trap_mstatus_calc: combinational entry/return mstatus and next-privilege computation, instantiated once.

## Test plan
- Pipeline exception, priv=U: exc_req, cause=2, pc=0x8000_0106, mstatus_in=0x8 → N+1: trap_taken, mepc_next=0x8000_0104, mcause_next=2, mstatus_next=0x80, priv=3 → N+2: redirect_pc = mtvec_trap & ~3.
- MRET in M, mstatus_in=0x1880, mepc_in=0x1000 → trap_done, mstatus_next=0x88, priv=3 → redirect_pc=0x1000.
- MRET in U (MPP=00 in mstatus_in) → trap_taken, mcause_next=2, mtval_next=0, priv stays 3.
- exc_req(cause 4) and csr_exc_en(code 2) in the same cycle → mcause_next=4. Second exc_req in N+1 → ignored, busy=1 during N+1..N+2.
- Reset asserted in COMMIT → no redirect_valid, priv=3, busy=0 the next cycle.
